// File: rtl/gpio_serial_loader_if.sv
// rtl/gpio_serial_loader_if.sv - handshake, config fetch and serial chain signals of the GPIO serial loader
//
// Purpose: bundles the loader's request/status handshake, the per-pad
// configuration fetch bus and the serial chain outputs.
// Signals:
//   start        request to load the whole chain (one cycle)
//   busy         load in progress
//   done         one-cycle completion pulse
//   cfg_idx      pad index whose configuration word is requested
//   cfg_data     configuration word for cfg_idx (combinational from cfg_idx)
//   serial_clock chain shift clock, blocks capture on its rising edge
//   serial_data  chain serial data
//   serial_load  latch strobe to all control blocks
// Modports:
//   master  the loader
//   slave   register file / chain / requester side
interface gpio_serial_loader_if #(
   parameter int NPADS    = 38,
   parameter int CFG_BITS = 13
);
   localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;

   logic                start;
   logic                busy;
   logic                done;
   logic [IW-1:0]       cfg_idx;
   logic [CFG_BITS-1:0] cfg_data;
   logic                serial_clock;
   logic                serial_data;
   logic                serial_load;

   modport master (
      input  start, cfg_data,
      output busy, done, cfg_idx, serial_clock, serial_data, serial_load
   );

   modport slave (
      output start, cfg_data,
      input  busy, done, cfg_idx, serial_clock, serial_data, serial_load
   );
endinterface

// File: rtl/gpio_serial_loader.sv
// rtl/gpio_serial_loader.sv - shifts per-pad GPIO configuration words into the control block chain
//
// Purpose: on start, walks pads NPADS-1 down to 0, fetches each configuration
// word and shifts it MSB-first on serial_clock, then pulses serial_load once
// so every control block latches its new configuration together.
// Ports:
//   wb_clk_i  clock, all state changes on its rising edge
//   wb_rst_i  synchronous active-high reset
//   clkdiv    serial phase stretch (only with SERIAL_CLKDIV_EN defined)
//   bus       gpio_serial_loader_if.master (start/busy/done, cfg_idx/cfg_data,
//             serial_clock/serial_data/serial_load)
// Optional feature: SERIAL_CLKDIV_EN adds the clkdiv port; each SHIFT_LO and
// SHIFT_HI phase then lasts clkdiv+1 cycles (clkdiv captured at start).
module gpio_serial_loader #(
   parameter int NPADS    = 38,
   parameter int CFG_BITS = 13
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
`ifdef SERIAL_CLKDIV_EN
   input  logic [3:0]                 clkdiv,
`endif
   gpio_serial_loader_if.master       bus
);
   localparam int IW = (NPADS > 1) ? $clog2(NPADS) : 1;
   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(NPADS - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      LOAD
   } state_t;

   state_t              state;
   logic [CFG_BITS-1:0] shreg;
   logic [CFG_BITS-1:0] shifted;
   logic [BW-1:0]       bit_cnt;
   logic                phase_end;

   assign shifted = shreg << 1;

`ifdef SERIAL_CLKDIV_EN
   logic [3:0] div_q;
   logic [3:0] div_cnt;

   assign phase_end = (div_cnt == div_q);
`else
   assign phase_end = 1'b1;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state            <= IDLE;
         shreg            <= '0;
         bit_cnt          <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.cfg_idx      <= '0;
         bus.serial_clock <= 1'b0;
         bus.serial_data  <= 1'b0;
         bus.serial_load  <= 1'b0;
`ifdef SERIAL_CLKDIV_EN
         div_q            <= '0;
         div_cnt          <= '0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               // start while busy cannot reach here, so it is simply dropped
               if (bus.start) begin
                  state       <= FETCH;
                  bus.cfg_idx <= LAST_IDX;
                  bus.busy    <= 1'b1;
                  bit_cnt     <= '0;
`ifdef SERIAL_CLKDIV_EN
                  div_q       <= clkdiv;
                  div_cnt     <= '0;
`endif
               end
            end

            FETCH: begin
               // first bit is presented together with entry to SHIFT_LO
               shreg           <= bus.cfg_data;
               bus.serial_data <= bus.cfg_data[CFG_BITS-1];
               state           <= SHIFT_LO;
            end

            SHIFT_LO: begin
               if (phase_end) begin
                  bus.serial_clock <= 1'b1;
                  state            <= SHIFT_HI;
`ifdef SERIAL_CLKDIV_EN
                  div_cnt          <= '0;
               end else begin
                  div_cnt          <= div_cnt + 4'd1;
`endif
               end
            end

            SHIFT_HI: begin
               if (phase_end) begin
                  bus.serial_clock <= 1'b0;
                  shreg            <= shifted;
`ifdef SERIAL_CLKDIV_EN
                  div_cnt          <= '0;
`endif
                  if (bit_cnt != LAST_BIT) begin
                     // next bit goes out on the falling edge of serial_clock
                     bit_cnt         <= bit_cnt + BIT_ONE;
                     bus.serial_data <= shifted[CFG_BITS-1];
                     state           <= SHIFT_LO;
                  end else if (bus.cfg_idx != '0) begin
                     bus.cfg_idx <= bus.cfg_idx - IDX_ONE;
                     bit_cnt     <= '0;
                     state       <= FETCH;
                  end else begin
                     bus.serial_load <= 1'b1;
                     bus.serial_data <= 1'b0;
                     state           <= LOAD;
                  end
`ifdef SERIAL_CLKDIV_EN
               end else begin
                  div_cnt <= div_cnt + 4'd1;
`endif
               end
            end

            LOAD: begin
               bus.serial_load <= 1'b0;
               bus.busy        <= 1'b0;
               bus.done        <= 1'b1;
               state           <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Shifts per-pad GPIO configuration words from the housekeeping configuration register file into the serial chain of GPIO control blocks. Those blocks drive the `mprj_io_*` control inputs of the user-project pad ring. On a start pulse it walks all pads from the highest index to the lowest and shifts each word MSB-first on a generated `serial_clock`. It then issues a single `serial_load` strobe so that every control block latches its new configuration at once.

## Interface
Parameters:
- `NPADS`, default 38: number of control blocks in the chain; must be ≥1.
- `CFG_BITS`, default 13: configuration bits per control block; must be ≥1.

Ports:
- `wb_clk_i` input 1: sole clock. All state changes on its rising edge.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to load the whole chain.
- `cfg_idx` output `$clog2(NPADS)` (minimum 1): pad index whose word is requested.
- `cfg_data` input `CFG_BITS`: configuration word for `cfg_idx`. Combinational function of `cfg_idx`.
- `serial_clock` output 1: chain shift clock. Control blocks capture on its rising edge.
- `serial_data` output 1: chain serial data.
- `serial_load` output 1: latch strobe to all control blocks.
- `busy` output 1: load in progress.
- `done` output 1: one-cycle completion pulse.
- `clkdiv` input 4: present only with `SERIAL_CLKDIV_EN`; serial phase stretch.

## Operation
- All outputs are registered. Reset values: every output 0, `cfg_idx`=0, state IDLE.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD.
- **IDLE:** on `start`=1, go to FETCH with `cfg_idx`←NPADS-1, `busy`←1, bit counter←0. A `start` received while `busy`=1 is ignored; it is not queued.
- **FETCH:** lasts 1 cycle. At the end of FETCH, the shift register←`cfg_data`. Go to SHIFT_LO.
- **SHIFT_LO:** `serial_clock`=0; `serial_data`=shift register MSB.
- **SHIFT_HI:** `serial_clock`=1; `serial_data` is held unchanged.
- At the end of SHIFT_HI: shift the register left by one and increment the bit counter.
  - If bit counter < CFG_BITS, go to SHIFT_LO.
  - Else if `cfg_idx`≠0, decrement `cfg_idx`, clear the bit counter and go to FETCH.
  - Else go to LOAD.
- **LOAD:** lasts 1 cycle with `serial_load`=1 and `serial_clock`=0. Then go to IDLE with `busy`←0 and `done`←1 for exactly one cycle.
- Shift order: pad NPADS-1 is sent first, MSB first. After the load completes, block k holds `cfg_data`(k).
- Invariants:
  - `serial_load` and `serial_clock` are never high together.
  - `serial_data` changes only while `serial_clock`=0.
  - `serial_clock` is 0 whenever the state is not SHIFT_HI.
- Reset mid-operation: the block returns to IDLE within one cycle with all outputs 0. No `serial_load` or `done` is issued, and partially shifted chain contents are left unlatched.

## Timing
- `start` is sampled at edge E0. `busy` is high from the cycle after E0 for exactly NPADS·(2·CFG_BITS+1)+1 cycles.
- With defaults, `busy` is high for 1027 cycles and there are 494 `serial_clock` rising edges.
- `done` is high in the first cycle in which `busy` is low.
- `serial_data` is stable for one full cycle before and after each `serial_clock` rising edge.
- `cfg_idx` changes only on entry to FETCH. `cfg_data` must settle within that same cycle.
- The earliest point a new `start` is accepted is the same cycle `done` is high.

## Configuration
- `SERIAL_CLKDIV_EN` defined:
  - The `clkdiv` port exists and is sampled on `start` acceptance. Later changes during the load are ignored.
  - Each SHIFT_LO and SHIFT_HI phase lasts `clkdiv`+1 cycles.
  - FETCH and LOAD remain 1 cycle each.
  - Busy length = NPADS·(2·CFG_BITS·(`clkdiv`+1)+1)+1.
- `SERIAL_CLKDIV_EN` undefined: no `clkdiv` port and no divider counter. Every phase is 1 cycle, which is identical to `clkdiv`=0.

## Test plan
- **Basic load:** NPADS=3, CFG_BITS=4, words {pad0=0x1, pad1=0xA, pad2=0xF}, single `start` → serial stream 1111_1010_0001 on rising edges. Then one `serial_load` pulse, and `done` at busy-cycle 28. A behavioural chain model must end with pad0=0x1, pad1=0xA, pad2=0xF.
- **Defaults:** NPADS=38, CFG_BITS=13, all-ones words → 494 `serial_clock` edges, `busy` high for 1027 cycles, exactly one `serial_load` and one `done`.
- **Start while busy:** `start` pulsed at busy-cycle 5 and busy-cycle 20 → ignored; the stream and busy length are unchanged from the single-start case.
- **Reset mid-shift:** `wb_rst_i` asserted at busy-cycle 10 → the next cycle shows all outputs 0. A subsequent `start` produces a full, correct load.
- **Back-to-back:** `start` driven in the `done` cycle → a second load begins with `busy` high the next cycle. Both loads are complete and correct.
- **Divider (`SERIAL_CLKDIV_EN`):** `clkdiv`=3, NPADS=3, CFG_BITS=4 → each `serial_clock` high and low phase is 4 cycles and busy length is 100. Changing `clkdiv` mid-load has no effect.
